// File: rtl/aes_uart_ctrl_if.sv
// Handshake and datapath bundle between the UART-facing controller and its
// surroundings (UART RX/TX plus the combinational encipher block).
interface aes_uart_ctrl_if;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         tx_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic [127:0] key_text;
    logic [127:0] plain_text;
    logic [127:0] ct_in;
    logic         busy;
    logic         key_loaded;
    logic         done;
    logic         overrun;

    modport slave (
        input  rx_valid, rx_data, tx_ready, ct_in,
        output tx_valid, tx_data, key_text, plain_text, busy, key_loaded, done, overrun
    );

    modport master (
        output rx_valid, rx_data, tx_ready, ct_in,
        input  tx_valid, tx_data, key_text, plain_text, busy, key_loaded, done, overrun
    );
endinterface

// File: rtl/aes_uart_ctrl.sv
// Byte-serial sequencer around a combinational AES-128 core: parses K/P commands
// from UART RX, holds key/plaintext for a settling window, streams ciphertext out.
module aes_uart_ctrl #(
    parameter int         ENC_WAIT_CYCLES = 2,
    parameter logic [7:0] CMD_KEY         = 8'h4B,
    parameter logic [7:0] CMD_PT          = 8'h50
) (
    input  logic          clk,
    input  logic          rst,
    aes_uart_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RX_KEY, RX_PT, WAIT, TX} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(ENC_WAIT_CYCLES - 1);

    state_t       state, state_nxt;
    logic [3:0]   byte_cnt;
    logic [3:0]   wait_cnt;
    logic [127:0] key_reg, pt_reg, ct_reg;
    logic         key_loaded_r, done_r, overrun_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == CMD_KEY)     state_nxt = RX_KEY;
                else if (bus.rx_valid && bus.rx_data == CMD_PT) state_nxt = RX_PT;
            end
            RX_KEY: if (bus.rx_valid && byte_cnt == 4'd15) state_nxt = IDLE;
            RX_PT:  if (bus.rx_valid && byte_cnt == 4'd15) state_nxt = WAIT;
            WAIT:   if (wait_cnt == WAIT_LAST)             state_nxt = TX;
            TX:     if (bus.tx_ready && byte_cnt == 4'd15) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx_valid/busy decode only the state register, so neither sees tx_ready.
    always_comb begin
        bus.busy     = (state != IDLE);
        bus.tx_valid = (state == TX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt     <= '0;
            wait_cnt     <= '0;
            key_reg      <= '0;
            pt_reg       <= '0;
            ct_reg       <= '0;
            key_loaded_r <= 1'b0;
            done_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            case (state)
                RX_KEY: if (bus.rx_valid) begin
                    key_reg  <= {key_reg[119:0], bus.rx_data};
                    byte_cnt <= byte_cnt + 4'd1;
                    if (byte_cnt == 4'd15) key_loaded_r <= 1'b1;
                end
                RX_PT: if (bus.rx_valid) begin
                    pt_reg   <= {pt_reg[119:0], bus.rx_data};
                    byte_cnt <= byte_cnt + 4'd1;
                end
                WAIT: begin
                    overrun_r <= bus.rx_valid;
                    if (wait_cnt == WAIT_LAST) begin
                        ct_reg   <= bus.ct_in;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                TX: begin
                    overrun_r <= bus.rx_valid;
                    // byte_cnt wraps to 0 on the 16th handshake, ready for the next block
                    if (bus.tx_ready) begin
                        ct_reg   <= {ct_reg[119:0], 8'h00};
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == 4'd15) done_r <= 1'b1;
                    end
                end
                default: begin
                    byte_cnt <= '0;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.tx_data    = ct_reg[127:120];
    assign bus.key_text   = key_reg;
    assign bus.plain_text = pt_reg;
    assign bus.key_loaded = key_loaded_r;
    assign bus.done       = done_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: doc/aes_uart_ctrl.md
# aes_uart_ctrl

Byte-serial controller that sequences the combinational AES-128 `encipher` datapath between the UART receiver and transmitter. It parses a simple command stream from the UART RX side, assembles a 128-bit key and a 128-bit plaintext, and holds them on the `encipher` inputs. It waits a fixed settling window, captures `cipher_text`, and streams the 16 ciphertext bytes to the UART TX side under a valid/ready handshake.

## Interface
- `ENC_WAIT_CYCLES`, 2, cycles the `encipher` inputs are held stable before `ct_in` is sampled (multicycle path budget); legal range 1..15.
- `CMD_KEY`, 8'h4B, command byte ('K') that loads a new key.
- `CMD_PT`, 8'h50, command byte ('P') that loads a plaintext and starts encryption.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received UART byte.
- `tx_ready`  in  1  UART TX can accept a byte this cycle.
- `tx_valid`  out  1  `tx_data` holds a ciphertext byte.
- `tx_data`  out  8  ciphertext byte, MSB byte first.
- `key_text`  out  128  to `encipher.key_text`.
- `plain_text`  out  128  to `encipher.plain_text`.
- `ct_in`  in  128  from `encipher.cipher_text`.
- `busy`  out  1  high whenever state is not IDLE.
- `key_loaded`  out  1  sticky; set after a complete 16-byte key load.
- `done`  out  1  one-cycle pulse after the last ciphertext byte handshakes.
- `overrun`  out  1  one-cycle pulse when an RX byte is dropped during WAIT or TX.

## Operation
- States: IDLE, RX_KEY, RX_PT, WAIT, TX. A 4-bit byte counter and a 4-bit wait counter are used.
- IDLE:
  - `rx_valid` with `CMD_KEY` moves to RX_KEY.
  - `rx_valid` with `CMD_PT` moves to RX_PT.
  - Any other byte is ignored silently. This is not an overrun.
- RX_KEY / RX_PT:
  - Each accepted byte shifts in: reg <= {reg[119:0], rx_data}, so the first byte ends up in [127:120]. The counter increments.
  - On the 16th byte, RX_KEY sets `key_loaded` and returns to IDLE.
  - On the 16th byte, RX_PT moves to WAIT.
  - Bytes matching command codes are treated as data in these states.
- WAIT:
  - Holds `key_text` and `plain_text` constant for exactly ENC_WAIT_CYCLES cycles.
  - On the clock edge ending the last wait cycle, ct_reg <= `ct_in` and the state moves to TX.
- TX:
  - `tx_valid` = 1 and `tx_data` = ct_reg[127:120].
  - On `tx_valid && tx_ready`: ct_reg <= {ct_reg[119:0], 8'h00} and the counter increments.
  - `tx_data` stays stable while the byte has not been accepted.
  - After the 16th handshake, the state returns to IDLE and `done` pulses in that next cycle.
- `rx_valid` in WAIT or TX: the byte is discarded and `overrun` pulses the next cycle. No other state change occurs.
- A plaintext encryption with no key loaded uses key_reg = 0. This is legal, and `key_loaded` stays 0.
- The key persists across any number of 'P' commands until the next 'K' command or reset.

## Timing
- Reset (asynchronous, effective immediately):
  - State = IDLE; counters, key_reg, pt_reg and ct_reg = 0.
  - `tx_valid`, `busy`, `key_loaded`, `done` and `overrun` = 0.
- Reset asserted mid-operation aborts any transfer. The partial key or plaintext is lost and no `done` is issued.
- Latency: the 16th P byte is accepted at edge t. WAIT occupies cycles t+1 .. t+ENC_WAIT_CYCLES. `tx_valid` rises at cycle t+ENC_WAIT_CYCLES+1.
- With `tx_ready` held at 1, one byte is sent per cycle. 16 bytes take 16 cycles, then `done` follows in the next cycle.
- `busy` rises the cycle after a command byte is accepted. It falls in the same cycle `done` is high.
- Back-to-back: a command byte arriving in the cycle `done` is high is accepted normally, because the state is already IDLE.
- Outputs are registered. `tx_data` and `tx_valid` do not depend combinationally on `tx_ready`.

## Test plan
- **FIPS-197 vector:** send 'K' then 000102030405060708090a0b0c0d0e0f. Then send 'P' then 00112233445566778899aabbccddeeff with `tx_ready`=1. Required: `key_loaded`=1; TX bytes are 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; `tx_valid` rises exactly ENC_WAIT_CYCLES+1 cycles after the last P byte; `done` pulses once.
- **Backpressure:** same vector with `tx_ready` toggling randomly and held low for 10 cycles at byte 7. Required: `tx_data` is stable while stalled, byte order is unchanged, and each byte is sent exactly once.
- **Key reuse and garbage bytes:** send bytes 0x00 and 0x41 while in IDLE, then two consecutive 'P' blocks without a new key. Required: the garbage is ignored with no `overrun`, and both outputs match the reference model.
- **Overrun:** inject `rx_valid` 0x50 during WAIT and twice during TX. Required: three `overrun` pulses, ciphertext unchanged, and the controller returns to IDLE (the injected 'P' is not started).
- **Reset mid-RX:** assert `rst` after 8 key bytes. Required: all outputs are 0 immediately, `key_loaded`=0, and a subsequent full K/P sequence produces the correct ciphertext.
- **No key loaded:** send 'P' plus the FIPS plaintext straight after reset. Required: the ciphertext equals AES-128 with the all-zero key, and `key_loaded` stays 0.
